conv_seq: RTL

- Sequential, parametrised local-field engine for the p-bit array.
- Computes out = sum of W[i] over every i where state[i] is set, with the index term either forced in or forced out depending on mode.
- Processes LANES weights per clock, so PBITS/LANES cycles replace one giant combinational adder tree and the block meets timing at large PBITS.
- Valid/ready on input and output; sits between the p-bit update controller and the activation/RNG stage.

---
 rtl/conv_seq_if.sv | 36 +++
 rtl/conv_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/conv_seq_if.sv
// Request/result handshake bundle for conv_seq.
// Carries a bias field only when CONV_SEQ_BIAS_EN is defined.
interface conv_seq_if #(
  parameter int PBITS = 64,
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PBITS-1:0]        state;
  logic signed [31:0]      index;
  logic                    mode;
  logic [PBITS*WIDTH-1:0]  W;
`ifdef CONV_SEQ_BIAS_EN
  logic signed [WIDTH-1:0] bias;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out;
  logic                    out_sat;

  modport master (
    input  in_ready, out_valid, out, out_sat,
`ifdef CONV_SEQ_BIAS_EN
    output bias,
`endif
    output in_valid, state, index, mode, W, out_ready
  );

  modport slave (
    output in_ready, out_valid, out, out_sat,
`ifdef CONV_SEQ_BIAS_EN
    input  bias,
`endif
    input  in_valid, state, index, mode, W, out_ready
  );
endinterface

// File: rtl/conv_seq.sv
// Sequential local-field engine: sums LANES masked weights per clock.
// Optional CONV_SEQ_BIAS_EN adds a bias that seeds the accumulator.
module conv_seq #(
  parameter int PBITS = 64,
  parameter int LANES = 8,
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  conv_seq_if.slave bus
);
  localparam int NCHUNK = (PBITS + LANES - 1) / LANES;
  localparam int ACC_W  = WIDTH + $clog2(PBITS) + 1;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } st_t;

  st_t st, st_nx;

  logic [PBITS-1:0]        pst_q;
  logic signed [31:0]      idx_q;
  logic                    mode_q;
  logic [CW-1:0]           chunk;
  logic signed [ACC_W-1:0] acc;
  logic signed [WIDTH-1:0] out_q;
  logic                    sat_q;

  logic signed [WIDTH-1:0] wl [NCHUNK][LANES];
  logic                    en [NCHUNK][LANES];

  // Padding lanes past PBITS are tied off so every chunk looks alike.
  for (genvar c = 0; c < NCHUNK; c++) begin : g_c
    for (genvar l = 0; l < LANES; l++) begin : g_l
      localparam int I = c * LANES + l;
      if (I < PBITS) begin : g_v
        logic hit;
        assign hit      = (idx_q == I);
        assign wl[c][l] = bus.W[I*WIDTH +: WIDTH];
        assign en[c][l] = mode_q ? (pst_q[I] & ~hit)
                                 : (pst_q[I] | hit);
      end else begin : g_p
        assign wl[c][l] = '0;
        assign en[c][l] = 1'b0;
      end
    end
  end

  logic signed [ACC_W-1:0] lsum;
  logic signed [ACC_W-1:0] acc_nx;
  logic signed [WIDTH-1:0] out_nx;
  logic                    sat_nx;

  always_comb begin
    lsum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (en[chunk][l]) lsum = lsum + ACC_W'(wl[chunk][l]);
    end
    acc_nx = acc + lsum;
  end

  always_comb begin
    out_nx = acc_nx[WIDTH-1:0];
    sat_nx = 1'b0;
    if (acc_nx > MAXV) begin
      out_nx = MAXV[WIDTH-1:0];
      sat_nx = 1'b1;
    end else if (acc_nx < MINV) begin
      out_nx = MINV[WIDTH-1:0];
      sat_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (bus.in_valid)   st_nx = ACC;
      ACC:     if (chunk == LAST)  st_nx = DONE;
      DONE:    if (bus.out_ready)  st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pst_q  <= '0;
      idx_q  <= '0;
      mode_q <= 1'b0;
      chunk  <= '0;
      acc    <= '0;
      out_q  <= '0;
      sat_q  <= 1'b0;
    end else if (st == IDLE && bus.in_valid) begin
      pst_q  <= bus.state;
      idx_q  <= bus.index;
      mode_q <= bus.mode;
      chunk  <= '0;
`ifdef CONV_SEQ_BIAS_EN
      acc    <= ACC_W'(bus.bias);
`else
      acc    <= '0;
`endif
    end else if (st == ACC) begin
      acc   <= acc_nx;
      chunk <= chunk + 1'b1;
      if (chunk == LAST) begin
        out_q <= out_nx;
        sat_q <= sat_nx;
      end
    end
  end

  assign bus.in_ready  = (st == IDLE);
  assign bus.out_valid = (st == DONE);
  assign bus.out       = out_q;
  assign bus.out_sat   = sat_q;
endmodule
